vscale_imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the core fetch interface that the PC mux drives.

---
 rtl/vscale_imem_responder.sv | 165 ++++++++++++++++
 tb/tb_vscale_imem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_imem_responder.sv
// vscale_imem_responder: memory end of the core instruction-fetch port.
// An address phase is accepted when imem_req is high and imem_wait is low.
// The word, or an access-error flag, comes back after a programmable number
// of wait states. The word array is filled through a side-band load port and
// has no reset.
// Optional feature macro: IMEM_RANDOM_WAIT_EN. When it is defined, a 16-bit
// LFSR picks 0..WAIT_CYCLES wait states per access instead of a fixed count.
module vscale_imem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     imem_req,
   input  logic [31:0]              imem_addr,
   output logic                     imem_wait,
   output logic [31:0]              imem_rdata,
   output logic                     imem_badmem_e,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data
);

   localparam int unsigned AW      = $clog2(DEPTH);
   // The range check is done in 33 bits so that the top bound cannot wrap.
   localparam logic [32:0] BASE_33 = {1'b0, BASE_ADDR};
   localparam logic [32:0] TOP_33  = BASE_33 + (33'(DEPTH) << 2);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            err_q, err_d;
   logic [31:0]     mem_q [DEPTH];

   logic            accept_s;
   logic [AW-1:0]   idx_s;
   logic            err_s;
   logic [3:0]      wait_load_s;

   // An address phase completes only while no data phase is stalling.
   assign accept_s = imem_req & ~imem_wait;

   // Decode the fetch address into a word index and an access-error flag.
   always_comb begin
      idx_s = AW'((imem_addr - BASE_ADDR) >> 2);
      err_s = (imem_addr[1:0] != 2'b00)
            | ({1'b0, imem_addr} < BASE_33)
            | ({1'b0, imem_addr} >= TOP_33);
   end

`ifdef IMEM_RANDOM_WAIT_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic [4:0]  wait_mod_s;

   // Advance the Fibonacci LFSR (taps 16,14,13,11) once for every accepted fetch.
   always_comb begin
      if (accept_s) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end else begin
         lfsr_d = lfsr_q;
      end
      wait_mod_s  = {1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1);
      wait_load_s = wait_mod_s[3:0];
   end

   // LFSR state register, reseeded on reset so that runs repeat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // With a fixed wait count, every access loads the same count.
   always_comb begin
      wait_load_s = 4'(WAIT_CYCLES);
   end
`endif

   // Next state: latch a new access on accept, otherwise count down or retire.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_BUSY;
               cnt_d   = wait_load_s;
               idx_d   = idx_s;
               err_d   = err_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (accept_s) begin
               // Data-valid cycle that also accepts the next fetch.
               state_d = ST_BUSY;
               cnt_d   = wait_load_s;
               idx_d   = idx_s;
               err_d   = err_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Access-tracking registers. Reset discards any outstanding access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Word array written only by the load port. A load in the data-valid cycle
   // lands at the closing edge, so the returned word is the old one.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Fetch-port outputs are decoded from registered state only. They are zero
   // except in wait and data-valid cycles.
   always_comb begin
      imem_wait     = 1'b0;
      imem_rdata    = 32'd0;
      imem_badmem_e = 1'b0;
      if (state_q == ST_BUSY) begin
         if (cnt_q != 4'd0) begin
            imem_wait = 1'b1;
         end else if (err_q) begin
            imem_badmem_e = 1'b1;
         end else begin
            imem_rdata = mem_q[idx_q];
         end
      end else begin
         imem_wait = 1'b0;
      end
   end

endmodule

// File: tb/tb_vscale_imem_responder.sv
// Self-checking bench for vscale_imem_responder.
// Four instances share the clock, reset and load port. Their WAIT_CYCLES are
// 0, 2, 3 and 7. A word-array model and an access-error rule derived from the
// address map give the expected data. The expected wait count is either the
// fixed WAIT_CYCLES or, with IMEM_RANDOM_WAIT_EN, the LFSR value modulo
// (WAIT_CYCLES+1).
module tb_vscale_imem_responder;

   localparam int          DEPTH = 64;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] BASE  = 32'h0000_0200;
   localparam int          NI    = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req    [NI];
   logic [31:0]   addr   [NI];
   logic          wait_o [NI];
   logic [31:0]   rdata  [NI];
   logic          bad    [NI];
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;

   int            tests_run    = 0;
   int            tests_failed = 0;
   logic [31:0]   mem_m  [DEPTH];
   logic [15:0]   lfsr_m [NI];
   int            waits_a [64];
   int            waits_b [64];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      vscale_imem_responder #(
         .DEPTH      (DEPTH),
         .BASE_ADDR  (BASE),
         .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 7)
      ) u_dut (
         .clk          (clk),
         .reset_n      (reset_n),
         .imem_req     (req[g]),
         .imem_addr    (addr[g]),
         .imem_wait    (wait_o[g]),
         .imem_rdata   (rdata[g]),
         .imem_badmem_e(bad[g]),
         .load_en      (load_en),
         .load_addr    (load_addr),
         .load_data    (load_data)
      );
   end

   function automatic int wait_cfg(int g);
      case (g)
         0:       return 0;
         1:       return 2;
         2:       return 3;
         default: return 7;
      endcase
   endfunction

   function automatic bit exp_bad(logic [31:0] a);
      longint la;
      la = longint'(a);
      return (a[1:0] != 2'b00) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
   endfunction

   function automatic logic [31:0] exp_data(logic [31:0] a);
      if (exp_bad(a)) return 32'd0;
      return mem_m[(a - BASE) >> 2];
   endfunction

   // Expected wait states of the next accept on instance g.
   task automatic take_wait(input int g, output int w);
`ifdef IMEM_RANDOM_WAIT_EN
      logic fb;
      w  = int'(lfsr_m[g][3:0]) % (wait_cfg(g) + 1);
      fb = lfsr_m[g][15] ^ lfsr_m[g][13] ^ lfsr_m[g][12] ^ lfsr_m[g][10];
      lfsr_m[g] = {lfsr_m[g][14:0], fb};
`else
      w = wait_cfg(g);
`endif
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NI; i++) lfsr_m[i] = 16'hACE1;
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = AW'(idx);
      load_data = d;
      @(posedge clk);
      #1;
      load_en = 1'b0;
      mem_m[idx] = d;
   endtask

   // One fetch. It is entered #1 after a posedge with wait_o[g] low and
   // returns #1 after the posedge that opens the data-valid cycle.
   task automatic fetch(input int g, input logic [31:0] a, output int seen);
      int          ew;
      logic [31:0] ed;
      logic        eb;
      take_wait(g, ew);
      ed = exp_data(a);
      eb = exp_bad(a);
      req[g]  = 1'b1;
      addr[g] = a;
      @(posedge clk);
      #1;
      req[g]  = 1'b0;
      addr[g] = $urandom;
      seen = 0;
      while (wait_o[g] === 1'b1 && seen < 40) begin
         tests_run++;
         if (rdata[g] !== 32'd0 || bad[g] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_outputs g=%0d addr=%h rdata=%h bad=%b required 00000000/0", g, a, rdata[g], bad[g]);
         end
         seen++;
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (seen !== ew) begin
         tests_failed++;
         $display("FAIL wait_count g=%0d addr=%h got %0d required %0d", g, a, seen, ew);
      end
      tests_run++;
      if (rdata[g] !== ed || bad[g] !== eb) begin
         tests_failed++;
         $display("FAIL fetch_data g=%0d addr=%h got %h/%b required %h/%b", g, a, rdata[g], bad[g], ed, eb);
      end
   endtask

   task automatic test_reset();
      #2;
      for (int g = 0; g < NI; g++) begin
         tests_run++;
         if (wait_o[g] !== 1'b0 || rdata[g] !== 32'd0 || bad[g] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs g=%0d got %b/%h/%b required 0/00000000/0", g, wait_o[g], rdata[g], bad[g]);
         end
      end
      do_reset();
      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      for (int g = 0; g < NI; g++) begin
         tests_run++;
         if (wait_o[g] !== 1'b0 || rdata[g] !== 32'd0 || bad[g] !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_outputs g=%0d got %b/%h/%b required 0/00000000/0", g, wait_o[g], rdata[g], bad[g]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int w0, w1;
      load_word(0, 32'h0000_0013);
      load_word(1, 32'h0010_0093);
      take_wait(0, w0);
      take_wait(0, w1);
      req[0]  = 1'b1;
      addr[0] = BASE;
      @(posedge clk);
      #1;
      tests_run++;
      if (wait_o[0] !== 1'b0 || rdata[0] !== 32'h0000_0013 || bad[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first got %b/%h/%b required 0/00000013/0", wait_o[0], rdata[0], bad[0]);
      end
      addr[0] = BASE + 32'd4;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      tests_run++;
      if (wait_o[0] !== 1'b0 || rdata[0] !== 32'h0010_0093 || bad[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_second got %b/%h/%b required 0/00100093/0", wait_o[0], rdata[0], bad[0]);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (wait_o[0] !== 1'b0 || rdata[0] !== 32'd0 || bad[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle got %b/%h/%b required 0/00000000/0", wait_o[0], rdata[0], bad[0]);
      end
   endtask

   task automatic test_wait3();
      int seen;
      fetch(2, BASE + 32'd4, seen);
      @(posedge clk);
      #1;
   endtask

   task automatic test_errors();
      logic [31:0] al [6];
      int          seen;
      al[0] = BASE + 32'd2;
      al[1] = BASE - 32'd4;
      al[2] = BASE + 32'(4 * DEPTH);
      al[3] = BASE + 32'(4 * DEPTH - 4);
      al[4] = 32'hFFFF_FFFC;
      al[5] = 32'h0000_0000;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 6; i++) fetch(g, al[i], seen);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      int ew, seen;
      take_wait(1, ew);
      req[1]  = 1'b1;
      addr[1] = BASE + 32'd8;
      @(posedge clk);
      #1;
      req[1] = 1'b0;
      tests_run++;
      if (wait_o[1] !== (ew > 0)) begin
         tests_failed++;
         $display("FAIL mid_wait_before_reset got %b required %b", wait_o[1], (ew > 0));
      end
      reset_n = 1'b0;
      #1;
      for (int g = 0; g < NI; g++) begin
         tests_run++;
         if (wait_o[g] !== 1'b0 || rdata[g] !== 32'd0 || bad[g] !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset g=%0d got %b/%h/%b required 0/00000000/0", g, wait_o[g], rdata[g], bad[g]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NI; i++) lfsr_m[i] = 16'hACE1;
      @(posedge clk);
      #1;
      fetch(1, BASE + 32'd8, seen);
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_collision();
      int          ew, seen;
      logic [31:0] old_w, new_w;
      take_wait(0, ew);
      req[0]  = 1'b1;
      addr[0] = BASE + 32'd4;
      @(posedge clk);
      #1;
      req[0]    = 1'b0;
      old_w     = mem_m[1];
      new_w     = ~old_w;
      load_en   = 1'b1;
      load_addr = AW'(1);
      load_data = new_w;
      tests_run++;
      if (rdata[0] !== old_w || bad[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_collision_old got %h/%b required %h/0", rdata[0], bad[0], old_w);
      end
      @(posedge clk);
      #1;
      load_en  = 1'b0;
      mem_m[1] = new_w;
      fetch(0, BASE + 32'd4, seen);
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int          seen, r;
      logic [31:0] a;
      for (int g = 0; g < NI; g++) begin
         for (int n = 0; n < 16; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 8) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
            fetch(g, a, seen);
            if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, DEPTH - 1), $urandom);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random_wait_repeat();
      int seen;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         fetch(3, BASE + 32'(4 * (i % DEPTH)), seen);
         waits_a[i] = seen;
         tests_run++;
         if (seen > 7) begin
            tests_failed++;
            $display("FAIL wait_bound run1 i=%0d got %0d required <=7", i, seen);
         end
      end
      do_reset();
      for (int i = 0; i < 64; i++) begin
         fetch(3, BASE + 32'(4 * (i % DEPTH)), seen);
         waits_b[i] = seen;
      end
      for (int i = 0; i < 64; i++) begin
         tests_run++;
         if (waits_b[i] !== waits_a[i]) begin
            tests_failed++;
            $display("FAIL wait_repeat i=%0d got %0d required %0d", i, waits_b[i], waits_a[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = 32'd0;
      for (int g = 0; g < NI; g++) begin
         req[g]    = 1'b0;
         addr[g]   = 32'd0;
         lfsr_m[g] = 16'hACE1;
      end
      test_reset();
      test_back_to_back();
      test_wait3();
      test_errors();
      test_reset_mid_wait();
      test_load_collision();
      test_random();
      test_random_wait_repeat();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached, %0d tests run", tests_run);
      $fatal(1, "watchdog");
   end

endmodule
